// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel valid/ready arbiter mux with fixed-select or round-robin grant and a registered output stage.
// Optional packet locking on a per-channel last flag (il) when MUX_ARB_LOCK_EN is defined.
module mux_arb_n #(
    parameter int unsigned W  = 16,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] i,
    input  logic [N-1:0]   iv,
    output logic [N-1:0]   ir,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    output logic [W-1:0]   o,
    output logic           ov,
    input  logic           ordy,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N-1:0]   il,
`endif
    output logic [SW-1:0]  og
);
    logic [SW-1:0] ptr;
    logic          ld;
    logic          gnt_v;
    logic [SW-1:0] gnt;
    logic          take;
    logic          unlock;
    logic [W-1:0]  gnt_data;
    logic [SW-1:0] ptr_nxt;
    int unsigned   idx;

`ifdef MUX_ARB_LOCK_EN
    logic          lock;
    logic [SW-1:0] lock_ch;
`endif

    // Grant selection: an open packet overrides mode; otherwise fixed select or round-robin from ptr.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        idx   = 0;
`ifdef MUX_ARB_LOCK_EN
        if (lock) begin
            gnt_v = iv[lock_ch];
            gnt   = lock_ch;
        end else
`endif
        if (!mode) begin
            if (32'(s) < N) begin
                gnt_v = iv[s];
                gnt   = s;
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = 32'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!gnt_v && iv[idx]) begin
                    gnt_v = 1'b1;
                    gnt   = SW'(idx);
                end
            end
        end
    end

    always_comb begin
        ld       = !ov || ordy;
        take     = rst_n && ld && gnt_v;
        ir       = take ? (N'(1) << gnt) : '0;
        gnt_data = i[32'(gnt)*W +: W];
        ptr_nxt  = (32'(gnt) == N - 1) ? '0 : gnt + SW'(1);
`ifdef MUX_ARB_LOCK_EN
        unlock   = il[gnt];
`else
        unlock   = 1'b1;
`endif
    end

    // Output stage, round-robin pointer and packet lock state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o   <= '0;
            ov  <= 1'b0;
            og  <= '0;
            ptr <= '0;
`ifdef MUX_ARB_LOCK_EN
            lock    <= 1'b0;
            lock_ch <= '0;
`endif
        end else begin
            if (take) begin
                o  <= gnt_data;
                og <= gnt;
                ov <= 1'b1;
            end else if (ordy) begin
                ov <= 1'b0;
            end
            if (take && mode && unlock) ptr <= ptr_nxt;
`ifdef MUX_ARB_LOCK_EN
            if (take) begin
                lock    <= !il[gnt];
                lock_ch <= gnt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench for mux_arb_n: directed scenarios plus randomized traffic against a rule-level model.
`timescale 1ns/1ps
module tb_mux_arb_n;
    localparam int unsigned W  = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned W3 = 8;
    localparam int unsigned N3 = 3;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LK_EN = 1'b1;
`else
    localparam bit LK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N*W-1:0] i;
    logic [N-1:0]   iv, ir, il;
    logic           mode, ov, ordy;
    logic [SW-1:0]  s, og;
    logic [W-1:0]   o;

    logic            rst3;
    logic [N3*W3-1:0] i3;
    logic [N3-1:0]   iv3, ir3, il3;
    logic            mode3, ov3, ordy3;
    logic [1:0]      s3, og3;
    logic [W3-1:0]   o3;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    int         m_ptr  = 0;
    bit         m_lock = 1'b0;
    int         m_lk   = 0;
    bit         m_ov   = 1'b0;
    logic [W-1:0] m_o  = '0;
    int         m_og   = 0;

    mux_arb_n #(.W(W), .N(N), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .i(i), .iv(iv), .ir(ir), .mode(mode), .s(s),
        .o(o), .ov(ov), .ordy(ordy),
`ifdef MUX_ARB_LOCK_EN
        .il(il),
`endif
        .og(og)
    );

    mux_arb_n #(.W(W3), .N(N3), .SW(2)) dut3 (
        .clk(clk), .rst_n(rst3), .i(i3), .iv(iv3), .ir(ir3), .mode(mode3), .s(s3),
        .o(o3), .ov(ov3), .ordy(ordy3),
`ifdef MUX_ARB_LOCK_EN
        .il(il3),
`endif
        .og(og3)
    );

    // Channel that the rules say wins this cycle, or -1.
    function automatic int ref_grant();
        if (LK_EN && m_lock) return iv[m_lk] ? m_lk : -1;
        if (!mode) return (s < N && iv[s]) ? int'(s) : -1;
        for (int j = 0; j < int'(N); j++) begin
            int c;
            c = (m_ptr + j) % int'(N);
            if (iv[c]) return c;
        end
        return -1;
    endfunction

    // One cycle on the N=4 instance: check ir, clock, advance model, check outputs.
    task automatic step(input string tag);
        int g;
        bit ld, unl, was_rst;
        logic [N-1:0] eir;
        #1;
        ld  = !m_ov || ordy;
        g   = ref_grant();
        eir = '0;
        if (rst_n && ld && g >= 0) eir[g] = 1'b1;
        nvec++;
        if (ir !== eir) begin
            nerr++;
            $display("FAIL %s ir: got %b want %b", tag, ir, eir);
        end
        was_rst = !rst_n;
        @(posedge clk);
        if (was_rst) begin
            m_ov = 0; m_o = '0; m_og = 0; m_ptr = 0; m_lock = 0; m_lk = 0;
        end else if (eir != '0) begin
            m_o  = i[g*W +: W];
            m_og = g;
            m_ov = 1'b1;
            unl  = !LK_EN || il[g];
            if (mode && unl) m_ptr = (g + 1) % int'(N);
            if (LK_EN) begin
                m_lock = !il[g];
                m_lk   = g;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
        nvec++;
        if (ov !== m_ov) begin
            nerr++;
            $display("FAIL %s ov: got %b want %b", tag, ov, m_ov);
        end
        if (m_ov || was_rst) begin
            nvec++;
            if (o !== m_o || og !== SW'(m_og)) begin
                nerr++;
                $display("FAIL %s o/og: got %h/%0d want %h/%0d", tag, o, og, m_o, m_og);
            end
        end
    endtask

    task automatic test_n3_rr();
        logic [N3-1:0] exp_ir;
        int exp_g;
        rst3 = 1'b0; mode3 = 1'b1; iv3 = 3'b101; ordy3 = 1'b1; s3 = 2'd0; il3 = '1;
        i3 = N3*W3'($urandom);
        @(posedge clk); #1;
        rst3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k % 2 == 0) ? 0 : 2;
            exp_ir = N3'(1) << exp_g;
            i3 = {W3'($urandom), W3'($urandom), W3'($urandom)};
            #1;
            nvec++;
            if (ir3 !== exp_ir) begin
                nerr++;
                $display("FAIL n3_rr ir k=%0d: got %b want %b", k, ir3, exp_ir);
            end
            @(posedge clk); #1;
            nvec++;
            if (og3 !== 2'(exp_g) || ov3 !== 1'b1 || o3 !== i3[exp_g*W3 +: W3]) begin
                nerr++;
                $display("FAIL n3_rr out k=%0d: got og=%0d ov=%b o=%h want og=%0d ov=1", k, og3, ov3, o3, exp_g);
            end
        end
    endtask

    task automatic test_n3_bad_sel();
        rst3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1; mode3 = 1'b0; s3 = 2'd3; iv3 = 3'b111; ordy3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            nvec++;
            if (ir3 !== 3'b000) begin
                nerr++;
                $display("FAIL n3_bad_sel ir: got %b want 000", ir3);
            end
            @(posedge clk); #1;
            nvec++;
            if (ov3 !== 1'b0) begin
                nerr++;
                $display("FAIL n3_bad_sel ov: got %b want 0", ov3);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; iv = '1; ordy = 1'b1; s = '0; il = '1;
        i = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        step("reset0");
        step("reset1");
        nvec++;
        if (ov !== 1'b0 || o !== '0 || og !== '0) begin
            nerr++;
            $display("FAIL reset_state: got ov=%b o=%h og=%0d want 0/0/0", ov, o, og);
        end
    endtask

    task automatic test_rr_full();
        rst_n = 1'b1; mode = 1'b1; iv = 4'b1111; ordy = 1'b1; il = '1;
        for (int k = 0; k < 8; k++) begin
            i = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
            step("rr_full");
            nvec++;
            if (og !== SW'(k % 4) || ov !== 1'b1) begin
                nerr++;
                $display("FAIL rr_full seq k=%0d: got og=%0d ov=%b want og=%0d ov=1", k, og, ov, k % 4);
            end
        end
    endtask

    task automatic test_fixed_stall();
        logic [W-1:0] d2;
        mode = 1'b0; s = 2'd2; iv = 4'b0100; ordy = 1'b1; il = '1;
        i = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        d2 = i[2*W +: W];
        step("fixed_load");
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
            step("fixed_stall");
            nvec++;
            if (o !== d2 || ov !== 1'b1 || og !== 2'd2 || ir !== '0) begin
                nerr++;
                $display("FAIL fixed_stall hold: got o=%h ov=%b og=%0d ir=%b want o=%h ov=1 og=2 ir=0",
                         o, ov, og, ir, d2);
            end
        end
        ordy = 1'b1;
        step("fixed_release");
    endtask

    task automatic test_reset_stall();
        mode = 1'b1; iv = 4'b1111; ordy = 1'b1; il = '1;
        step("rst_stall_load");
        ordy = 1'b0;
        step("rst_stall_hold");
        rst_n = 1'b0;
        step("rst_stall_rst");
        nvec++;
        if (ov !== 1'b0 || o !== '0 || og !== '0) begin
            nerr++;
            $display("FAIL rst_stall clear: got ov=%b o=%h og=%0d want 0/0/0", ov, o, og);
        end
        rst_n = 1'b1; ordy = 1'b1;
        step("rst_stall_restart");
        nvec++;
        if (og !== 2'd0 || ov !== 1'b1) begin
            nerr++;
            $display("FAIL rst_stall restart: got og=%0d ov=%b want 0/1", og, ov);
        end
    endtask

    task automatic test_lock();
        int exp_og[4] = '{1, 1, 1, 2};
        logic [N-1:0] ils[4] = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
        rst_n = 1'b0; il = '1;
        step("lock_rst");
        rst_n = 1'b1; mode = 1'b1; iv = 4'b1111; ordy = 1'b1;
        step("lock_ch0");
        for (int k = 0; k < 4; k++) begin
            il = ils[k];
            step("lock_pkt");
            nvec++;
            if (og !== SW'(exp_og[k])) begin
                nerr++;
                $display("FAIL lock seq k=%0d: got og=%0d want %0d", k, og, exp_og[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(49) != 0);
            mode  = ($urandom_range(3) != 0);
            s     = SW'($urandom);
            iv    = N'($urandom);
            ordy  = ($urandom_range(3) != 0);
            il    = N'($urandom);
            i     = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
            step("random");
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b1; iv = '0; ordy = 1'b1; s = '0; il = '1; i = '0;
        rst3 = 1'b0; mode3 = 1'b1; iv3 = '0; ordy3 = 1'b1; s3 = '0; il3 = '1; i3 = '0;
        test_n3_rr();
        test_n3_bad_sel();
        @(posedge clk); #1;
        test_reset();
        test_rr_full();
        test_fixed_stall();
        test_reset_stall();
        if (LK_EN) test_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter W, default 16, data width per channel in bits (>=1).
REQ-002 Parameter N, default 4, channel count (2..16, non-power-of-two allowed).
REQ-003 Parameter SW, default 2, select width; SHALL satisfy 2**SW >= N.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 i  input  N*W  flattened channel data; channel k occupies i[k*W+W-1:k*W].
REQ-007 iv  input  N  per-channel valid.
REQ-008 ir  output  N  per-channel ready, one-hot or zero, combinational.
REQ-009 mode  input  1  0 = fixed select by s, 1 = round-robin.
REQ-010 s  input  SW  channel select, used in fixed mode only.
REQ-011 o  output  W  registered output data.
REQ-012 ov  output  1  registered output valid.
REQ-013 ordy  input  1  downstream ready.
REQ-014 og  output  SW  registered index of channel that supplied o.

Function
REQ-015 Output register SHALL load when ld = (!ov | ordy) and a channel is granted; transfer on channel k = iv[k] & ir[k].
REQ-016 ir[k] SHALL be 1 only for the granted channel k, and only when ld=1; all other bits 0.
REQ-017 Latency: accepted beat SHALL appear on o/ov/og the next cycle; throughput one beat per cycle with ordy held high.
REQ-018 ov SHALL clear when ordy=1 and no channel is granted; o and og SHALL hold while ov=1 and ordy=0.
REQ-019 Fixed mode: grant channel s if s < N and iv[s]=1; s >= N SHALL grant nothing.
REQ-020 Round-robin mode: search channels ptr, ptr+1, ... mod N; grant first with iv=1.
REQ-021 ptr SHALL update to (k+1) mod N on each accepted beat from k in round-robin mode only; wrap from N-1 to 0 for any N.
REQ-022 ptr SHALL hold in fixed mode; mode/s changes SHALL take effect in the same cycle's arbitration.
REQ-023 No valid input and ld=1: no grant, ptr unchanged.

Reset
REQ-024 rst_n=0 at a rising edge SHALL set ov=0, o=0, og=0, ptr=0, lock state clear; in-flight beat discarded.
REQ-025 While rst_n=0, ir SHALL be all zero.
REQ-026 Reset mid-stall (ov=1, ordy=0) SHALL drop the held beat with no further output.

Configuration
REQ-027 Macro MUX_ARB_LOCK_EN: when defined, add input il (N bits, per-channel last flag) and packet locking.
REQ-028 With MUX_ARB_LOCK_EN: accepting a beat from k with il[k]=0 SHALL lock grant to k; only k is eligible (s, mode, ptr ignored) until a beat from k with il[k]=1 is accepted, which unlocks.
REQ-029 With MUX_ARB_LOCK_EN: ptr SHALL advance only on the unlocking (il=1) beat in round-robin mode.
REQ-030 Without MUX_ARB_LOCK_EN: no il port; every beat arbitrated independently per REQ-019..REQ-023.

Verification
REQ-031 N=4, mode=1, iv=4'b1111, ordy=1, 8 cycles -> og sequence 0,1,2,3,0,1,2,3 one cycle after each grant, ov continuously 1.
REQ-032 N=3, mode=1, iv=3'b101 -> og alternates 0,2,0,2; ptr wraps 2->0.
REQ-033 mode=0, s=2, iv=4'b0100, ordy=0 after first beat -> ov=1, o holds channel 2 data, ir=0 until ordy=1.
REQ-034 N=3, mode=0, s=3, iv=3'b111 -> ir=0, ov stays 0.
REQ-035 rst_n=0 for one cycle while ov=1, ordy=0 -> next cycle ov=0, o=0, og=0, then round-robin restarts at channel 0.
REQ-036 MUX_ARB_LOCK_EN, mode=1, channel 1 sends 3 beats il=0,0,1 with iv=4'b1111 -> og=1,1,1 then 2.
